// File: rtl/mem_arbiter_pkg.sv
// Shared widths, load/store size codes and arbiter state encodings for mem_arbiter and the core.
package mem_arbiter_pkg;

  localparam int XLEN       = 32;
  localparam int ADDR_WIDTH = 32;
  localparam int SL_WIDTH   = 2;

  localparam logic [SL_WIDTH-1:0] SL_B = 2'd0;
  localparam logic [SL_WIDTH-1:0] SL_H = 2'd1;
  localparam logic [SL_WIDTH-1:0] SL_W = 2'd2;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  // Bytes never trap; halves need bit 0 clear, words need both low bits clear.
  function automatic logic is_misaligned(input logic [SL_WIDTH-1:0] size, input logic [1:0] lsb);
    logic r;
    r = 1'b0;
    case (size)
      SL_H:    r = lsb[0];
      SL_W:    r = (lsb != 2'b00);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response and RAM-port bundle of mem_arbiter; slave = arbiter side, master = core/RAM side.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic                  if_req_valid;
  logic                  if_req_ready;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_rsp_valid;
  logic [XLEN-1:0]       if_rsp_data;
  logic                  if_rsp_err;

  logic                  ls_req_valid;
  logic                  ls_req_ready;
  logic                  ls_we;
  logic [ADDR_WIDTH-1:0] ls_addr;
  logic [SL_WIDTH-1:0]   ls_size;
  logic                  ls_unsigned;
  logic [XLEN-1:0]       ls_wdata;
  logic                  ls_rsp_valid;
  logic [XLEN-1:0]       ls_rsp_data;
  logic                  ls_rsp_err;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [SL_WIDTH-1:0]   mem_size;
  logic [XLEN-1:0]       mem_wdata;
  logic [XLEN-1:0]       mem_rdata;

  modport slave (
    input  if_req_valid, if_addr,
    output if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
    input  ls_req_valid, ls_we, ls_addr, ls_size, ls_unsigned, ls_wdata,
    output ls_req_ready, ls_rsp_valid, ls_rsp_data, ls_rsp_err,
    output mem_en, mem_we, mem_addr, mem_size, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output if_req_valid, if_addr,
    input  if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
    output ls_req_valid, ls_we, ls_addr, ls_size, ls_unsigned, ls_wdata,
    input  ls_req_ready, ls_rsp_valid, ls_rsp_data, ls_rsp_err,
    input  mem_en, mem_we, mem_addr, mem_size, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/mem_arbiter_load_ext.sv
// Load extender: picks byte/half/word from the low lanes and sign- or zero-extends to XLEN.
// Purely combinational, no handshake.
module mem_arbiter_load_ext
  import mem_arbiter_pkg::*;
(
  input  logic [SL_WIDTH-1:0] i_size,
  input  logic                i_unsigned,
  input  logic [XLEN-1:0]     i_data,
  output logic [XLEN-1:0]     o_data
);

  always_comb begin
    o_data = i_data;
    case (i_size)
      SL_B:    o_data = {{(XLEN-8){~i_unsigned & i_data[7]}}, i_data[7:0]};
      SL_H:    o_data = {{(XLEN-16){~i_unsigned & i_data[15]}}, i_data[15:0]};
      default: o_data = i_data;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one RAM port between IF and LS (LS priority, starvation-bounded); handshake T -> rsp T+MEM_LAT+2,
// one access in flight, ready low outside IDLE, no response backpressure. MISALIGN_TRAP_EN traps misaligned requests.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam int LAT_W = $clog2(MEM_LAT + 1);

  arb_state_e            r_state, w_next;
  owner_e                r_owner;
  logic [CNT_W-1:0]      r_starve;
  logic [LAT_W-1:0]      r_cnt;
  logic                  r_we;
  logic                  r_unsigned;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [SL_WIDTH-1:0]   r_size;
  logic [XLEN-1:0]       r_wdata;
  logic [XLEN-1:0]       r_rdata;
  logic [XLEN-1:0]       w_ext;

  logic                  w_grant_ls, w_grant_if, w_hs, w_misalign;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [SL_WIDTH-1:0]   w_sel_size;

  // IF wins only once it has watched STARVE_MAX consecutive LS grants.
  assign w_grant_ls = bus.ls_req_valid && !(bus.if_req_valid && (r_starve == CNT_W'(STARVE_MAX)));
  assign w_grant_if = bus.if_req_valid && !w_grant_ls;
  assign w_hs       = (r_state == ARB_IDLE) && (w_grant_ls || w_grant_if);
  assign w_sel_addr = w_grant_ls ? bus.ls_addr : bus.if_addr;
  assign w_sel_size = w_grant_ls ? bus.ls_size : SL_W;

`ifdef MISALIGN_TRAP_EN
  logic r_err;
  assign w_misalign = is_misaligned(w_sel_size, w_sel_addr[1:0]);
`else
  assign w_misalign = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      ARB_IDLE:  if (w_hs) w_next = w_misalign ? ARB_RESP : ARB_ISSUE;
      ARB_ISSUE: w_next = ARB_WAIT;
      ARB_WAIT:  if (r_cnt == LAT_W'(1)) w_next = ARB_RESP;
      ARB_RESP:  w_next = ARB_IDLE;
      default:   w_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ARB_IDLE;
      r_owner    <= OWN_IF;
      r_starve   <= '0;
      r_cnt      <= '0;
      r_we       <= 1'b0;
      r_unsigned <= 1'b0;
      r_addr     <= '0;
      r_size     <= SL_W;
      r_wdata    <= '0;
      r_rdata    <= '0;
`ifdef MISALIGN_TRAP_EN
      r_err      <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      if (w_hs) begin
        r_owner    <= w_grant_ls ? OWN_LS : OWN_IF;
        r_starve   <= (w_grant_ls && bus.if_req_valid) ? r_starve + CNT_W'(1) : '0;
        r_we       <= w_grant_ls && bus.ls_we;
        r_unsigned <= w_grant_ls && bus.ls_unsigned;
        r_addr     <= w_sel_addr;
        r_size     <= w_sel_size;
        r_wdata    <= w_grant_ls ? bus.ls_wdata : '0;
        r_rdata    <= '0;
`ifdef MISALIGN_TRAP_EN
        r_err      <= w_misalign;
`endif
      end
      if (r_state == ARB_ISSUE) begin
        r_cnt <= LAT_W'(MEM_LAT);
      end else if (r_state == ARB_WAIT) begin
        r_cnt <= r_cnt - LAT_W'(1);
        if (r_cnt == LAT_W'(1)) r_rdata <= r_we ? '0 : w_ext;
      end
    end
  end

  mem_arbiter_load_ext u_ext (
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .i_data     (bus.mem_rdata),
    .o_data     (w_ext)
  );

  assign bus.ls_req_ready = (r_state == ARB_IDLE) && w_grant_ls;
  assign bus.if_req_ready = (r_state == ARB_IDLE) && w_grant_if;

  assign bus.mem_en    = (r_state == ARB_ISSUE);
  assign bus.mem_we    = (r_state == ARB_ISSUE) && r_we;
  assign bus.mem_addr  = (r_state == ARB_ISSUE) ? r_addr  : '0;
  assign bus.mem_size  = (r_state == ARB_ISSUE) ? r_size  : SL_W;
  assign bus.mem_wdata = (r_state == ARB_ISSUE) ? r_wdata : '0;

  assign bus.if_rsp_valid = (r_state == ARB_RESP) && (r_owner == OWN_IF);
  assign bus.ls_rsp_valid = (r_state == ARB_RESP) && (r_owner == OWN_LS);
  assign bus.if_rsp_data  = (r_owner == OWN_IF) ? r_rdata : '0;
  assign bus.ls_rsp_data  = (r_owner == OWN_LS) ? r_rdata : '0;

`ifdef MISALIGN_TRAP_EN
  assign bus.if_rsp_err = bus.if_rsp_valid && r_err;
  assign bus.ls_rsp_err = bus.ls_rsp_valid && r_err;
`else
  assign bus.if_rsp_err = 1'b0;
  assign bus.ls_rsp_err = 1'b0;
`endif

endmodule
